// File: rtl/iterative_extend_shifter_pkg.sv
// Shared encodings for the iterative extend/shift unit: operation codes,
// operand-source codes and the FSM state encoding.
package iterative_extend_shifter_pkg;

  // Shift operation selected by ShiftOp
  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Operand source selected by ShifterInput
  typedef enum logic [1:0] {
    SRC_ZIMM = 2'b00,
    SRC_SIMM = 2'b01,
    SRC_REGA = 2'b10,
    SRC_ALU  = 2'b11
  } src_sel_e;

  // Control FSM states; exported on dbg_state for observation
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_extend_shifter_extend_select.sv
// Operand selection: zero-extended short immediate, sign-extended long
// immediate, register A or the ALU result, widened to the datapath width.
module iterative_extend_shifter_extend_select
  import iterative_extend_shifter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_SHORT = 4,
  parameter int IMM_LONG  = 8
) (
  input  logic [1:0]           sel,
  input  logic [IMM_SHORT-1:0] ir_short,
  input  logic [IMM_LONG-1:0]  ir_long,
  input  logic [WIDTH-1:0]     reg_a,
  input  logic [WIDTH-1:0]     alu_out,
  output logic [WIDTH-1:0]     operand
);

  // Pick and extend the operand
  always_comb begin
    operand = '0;
    case (src_sel_e'(sel))
      SRC_ZIMM: operand = {{(WIDTH-IMM_SHORT){1'b0}}, ir_short};
      SRC_SIMM: operand = {{(WIDTH-IMM_LONG){ir_long[IMM_LONG-1]}}, ir_long};
      SRC_REGA: operand = reg_a;
      SRC_ALU:  operand = alu_out;
    endcase
  end

endmodule

// File: rtl/iterative_extend_shifter.sv
// Multi-cycle extend/shift unit. An accepted request latches the extended
// operand and an effective shift distance, then shifts STEP bits per cycle
// until the distance is consumed. O holds the last completed result.
//
// Handshake: a request is taken on a rising CLK edge where Start=1 and the
// unit is not Busy (state IDLE or DONE); Start while Busy is dropped, not
// queued. Busy is high for every SHIFT cycle; Done pulses for exactly one
// cycle when O has been updated.
module iterative_extend_shifter
  import iterative_extend_shifter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_SHORT = 4,
  parameter int IMM_LONG  = 8,
  parameter int STEP      = 1
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic [1:0]               ShifterInput,
  input  logic [1:0]               ShiftOp,
  input  logic [$clog2(WIDTH):0]   ShiftAmount,
  input  logic [IMM_SHORT-1:0]     IRShort,
  input  logic [IMM_LONG-1:0]      IRLong,
  input  logic [WIDTH-1:0]         Reg_A,
  input  logic [WIDTH-1:0]         ALUOut,
  output logic                     Busy,
  output logic                     Done,
  output logic [WIDTH-1:0]         O,
  output logic [1:0]               dbg_state
);

  localparam int AMT_W = $clog2(WIDTH) + 1;
  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);

  state_e           state;
  shift_op_e        op_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] stepped;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] eff;
  logic [AMT_W-1:0] k;

  iterative_extend_shifter_extend_select #(
    .WIDTH     (WIDTH),
    .IMM_SHORT (IMM_SHORT),
    .IMM_LONG  (IMM_LONG)
  ) u_extend_select (
    .sel      (ShifterInput),
    .ir_short (IRShort),
    .ir_long  (IRLong),
    .reg_a    (Reg_A),
    .alu_out  (ALUOut),
    .operand  (operand)
  );

  // Effective distance: rotates wrap, plain shifts saturate at WIDTH
  always_comb begin
    eff = ShiftAmount;
    if (shift_op_e'(ShiftOp) == OP_ROR) begin
      eff = ShiftAmount % WIDTH_A;
    end else if (ShiftAmount > WIDTH_A) begin
      eff = WIDTH_A;
    end
  end

  // One iteration: shift the work register by min(STEP, Rem)
  always_comb begin
    k = (rem > STEP_A) ? STEP_A : rem;
    stepped = work;
    case (op_q)
      OP_LSL: stepped = work << k;
      OP_LSR: stepped = work >> k;
      OP_ASR: stepped = WIDTH'($signed(work) >>> k);
      OP_ROR: stepped = (work >> k) | (work << (WIDTH_A - k));
    endcase
  end

  // Control FSM with registered Busy/Done/O
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      op_q  <= OP_LSL;
      work  <= '0;
      rem   <= '0;
      O     <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            work <= operand;
            rem  <= eff;
            op_q <= shift_op_e'(ShiftOp);
            if (eff == '0) begin
              // Nothing to shift: the result is the operand itself
              O     <= operand;
              Done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              Busy  <= 1'b1;
              state <= ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work <= stepped;
          rem  <= rem - k;
          if (rem == k) begin
            O     <= stepped;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
